// File: rtl/phv_stage_fifo.sv
// Inter-stage PHV buffer between one stage's action engine and the next
// stage's parser. The upstream side is valid-only and cannot stall, so the
// buffer raises an early ready_out warning and counts any PHV it must drop.
// The consumer side is first-word-fall-through valid/ready with a registered
// head, so phv_out stays put under stall and keeps its last value when empty.
module phv_stage_fifo #(
    parameter int PHV_LEN      = 1124,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PHV_LEN-1:0]         phv_in,
    input  logic                       phv_valid_in,
    output logic                       ready_out,
    output logic [PHV_LEN-1:0]         phv_out,
    output logic                       phv_valid_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - AFULL_MARGIN - 1);

    logic [PHV_LEN-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [PHV_LEN-1:0] r_phv_out;
    logic               r_valid;
    logic               r_ready;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic               r_overflow;

    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic [CW-1:0]      w_count_next;
    logic [AW-1:0]      w_rd_ptr_next;
    logic               w_head_is_new;
    logic [PHV_LEN-1:0] w_head_next;

    // r_valid always equals (r_count != 0); using it keeps pop off the counter compare.
    assign w_pop         = r_valid & ready_in;
    assign w_full        = (r_count == FULL_CNT);
    // A pop on a full FIFO frees the slot the incoming PHV needs.
    assign w_push        = phv_valid_in & (~w_full | w_pop);
    assign w_drop        = phv_valid_in & ~w_push;
    assign w_count_next  = r_count + CW'(w_push) - CW'(w_pop);
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop);
    // The incoming PHV becomes head when nothing older remains after this pop.
    assign w_head_is_new = w_push & (r_count == CW'(w_pop));
    assign w_head_next   = w_head_is_new ? phv_in : r_mem[w_rd_ptr_next];

    assign ready_out     = r_ready;
    assign phv_out       = r_phv_out;
    assign phv_valid_out = r_valid;
    assign occupancy     = r_count;
    assign drop_cnt      = r_drop_cnt;
    assign overflow      = r_overflow;

    // Entry storage; no reset, stale contents are never exposed.
    always_ff @(posedge clk) begin
        if (!rst && w_push)
            r_mem[r_wr_ptr] <= phv_in;
    end

    // Pointers, occupancy, registered head and early-warning ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_phv_out <= '0;
            r_ready   <= 1'b1;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != '0);
            r_ready  <= (w_count_next <= READY_MAX);
            // Head only reloads while something remains; empty keeps the last PHV.
            if (w_count_next != '0)
                r_phv_out <= w_head_next;
        end
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

endmodule
